// File: rtl/dcache_blocking_pkg.sv
// Shared sizes, address views and helpers for the dcache_blocking slice.
// The fill engine uses only the types it needs from here.
package dcache_blocking_pkg;

    localparam int DATA_W           = 32;
    localparam int MEM_DATA_W       = 64;
    localparam int RAM_DAT_LINE_N   = 4;
    localparam int RAM_TAG_ADDR_W   = 8;
    localparam int CACHE_LINE_TAG_W = 19;
    localparam int CACHE_WAYS_N     = 4;

    localparam int ADDR_W     = 32;
    localparam int BNK_W      = $clog2(RAM_DAT_LINE_N);
    localparam int BYTE_W     = $clog2(MEM_DATA_W / 8);
    localparam int LINE_OFF_W = BNK_W + BYTE_W;

    typedef logic [DATA_W-1:0]           data_t;
    typedef logic [MEM_DATA_W-1:0]       mem_data_t;
    typedef mem_data_t                   ram_dat_dat_t;
    typedef logic [BNK_W-1:0]            ram_dat_line_t;
    typedef logic [RAM_DAT_LINE_N-1:0]   ram_dat_bnk_n_t;
    typedef logic [CACHE_WAYS_N-1:0]     ways_t;
    typedef logic [RAM_TAG_ADDR_W-1:0]   cache_line_off_t;
    typedef logic [CACHE_LINE_TAG_W-1:0] cache_line_tag_t;

    // Two views of one byte address: bank/byte position, and tag/set split.
    typedef struct packed {
        logic [ADDR_W-LINE_OFF_W-1:0] h;
        ram_dat_line_t                b;
        logic [BYTE_W-1:0]            o;
    } addr_pos_t;

    typedef struct packed {
        cache_line_tag_t         t;
        cache_line_off_t         o;
        logic [LINE_OFF_W-1:0]   f;
    } addr_line_t;

    typedef union packed {
        addr_pos_t  p;
        addr_line_t l;
    } addr_t;

    typedef enum logic [2:0] {
        FILL_IDLE,
        FILL_INV,
        FILL_REQ,
        FILL_DATA,
        FILL_TAG
    } fill_state_t;

    function automatic ram_dat_bnk_n_t bank_onehot(input ram_dat_line_t b);
        bank_onehot = ram_dat_bnk_n_t'(1) << b;
    endfunction

endpackage

// File: rtl/dcache_blocking_fill.sv
// Blocking line-fill engine: invalidate victim, fetch four beats critical-first,
// write the data banks, forward the critical word, then install the valid tag.
module dcache_blocking_fill
    import dcache_blocking_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fill_req_vld,
    output logic            fill_req_rdy,
    input  addr_t           fill_req_addr,
    input  ways_t           fill_req_way,
    output logic            mem_req_vld,
    input  logic            mem_req_rdy,
    output addr_t           mem_req_addr,
    input  logic            mem_rsp_vld,
    input  mem_data_t       mem_rsp_data,
    output logic            ram_dat_en,
    output ways_t           ram_dat_way,
    output ram_dat_bnk_n_t  ram_dat_bnk,
    output cache_line_off_t ram_dat_idx,
    output ram_dat_dat_t    ram_dat_wdata,
    output logic            ram_tag_en,
    output ways_t           ram_tag_way,
    output cache_line_off_t ram_tag_idx,
    output cache_line_tag_t ram_tag_wtag,
    output logic            ram_tag_wvld,
    output logic            crit_vld,
    output data_t           crit_data,
    output logic            fill_done,
    output logic            busy
);

    fill_state_t   state;
    addr_t         addr_q;
    ways_t         way_q;
    ram_dat_line_t cnt_q;
    ram_dat_line_t bank_sel;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= FILL_IDLE;
            addr_q <= '0;
            way_q  <= '0;
            cnt_q  <= '0;
        end else begin
            case (state)
                FILL_IDLE: if (fill_req_vld) begin
                    addr_q <= fill_req_addr;
                    way_q  <= fill_req_way;
                    state  <= FILL_INV;
                end
                FILL_INV:  state <= FILL_REQ;
                FILL_REQ:  if (mem_req_rdy) begin
                    cnt_q <= '0;
                    state <= FILL_DATA;
                end
                FILL_DATA: if (mem_rsp_vld) begin
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state <= FILL_TAG;
                end
                FILL_TAG:  state <= FILL_IDLE;
                default:   state <= FILL_IDLE;
            endcase
        end
    end

    // Strobes are qualified with rst_n so nothing escapes while reset is held.
    assign fill_req_rdy = rst_n && (state == FILL_IDLE);
    assign busy         = rst_n && (state != FILL_IDLE);
    assign mem_req_vld  = rst_n && (state == FILL_REQ);
    assign ram_dat_en   = rst_n && (state == FILL_DATA) && mem_rsp_vld;
    assign crit_vld     = ram_dat_en && (cnt_q == 2'd0);
    assign ram_tag_en   = rst_n && ((state == FILL_INV) || (state == FILL_TAG));
    assign ram_tag_wvld = rst_n && (state == FILL_TAG);
    assign fill_done    = ram_tag_wvld;
    assign bank_sel     = addr_q.p.b + cnt_q;

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        mem_req_addr  = '0;
        ram_dat_way   = '0;
        ram_dat_bnk   = '0;
        ram_dat_idx   = '0;
        ram_dat_wdata = '0;
        crit_data     = '0;
        ram_tag_way   = '0;
        ram_tag_idx   = '0;
        ram_tag_wtag  = '0;
        if (mem_req_vld) begin
            mem_req_addr     = addr_q;
            mem_req_addr.p.o = '0;
        end
        if (ram_dat_en) begin
            ram_dat_way   = way_q;
            ram_dat_bnk   = bank_onehot(bank_sel);
            ram_dat_idx   = addr_q.l.o;
            ram_dat_wdata = mem_rsp_data;
        end
        if (crit_vld) begin
            crit_data = addr_q.p.o[2] ? mem_rsp_data[63:32] : mem_rsp_data[31:0];
        end
        if (ram_tag_en) begin
            ram_tag_way = way_q;
            ram_tag_idx = addr_q.l.o;
        end
        if (ram_tag_wvld) begin
            ram_tag_wtag = addr_q.l.t;
        end
    end

    // A beat outside DATA means the memory side lost track of the request.
    always_ff @(posedge clk) begin
        rsp_outside_data: assert (!(rst_n && mem_rsp_vld && (state != FILL_DATA)))
            else $warning("dcache_blocking_fill: mem_rsp_vld outside DATA ignored");
    end

endmodule

// File: tb/tb_dcache_blocking_fill.sv
// Directed bench for dcache_blocking_fill: hand-computed addresses, banks, tags
// and timing for normal, stalled, gapped, reset-interrupted and back-to-back fills.
module tb_dcache_blocking_fill;
    import dcache_blocking_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            fill_req_vld;
    logic            fill_req_rdy;
    addr_t           fill_req_addr;
    ways_t           fill_req_way;
    logic            mem_req_vld;
    logic            mem_req_rdy;
    addr_t           mem_req_addr;
    logic            mem_rsp_vld;
    mem_data_t       mem_rsp_data;
    logic            ram_dat_en;
    ways_t           ram_dat_way;
    ram_dat_bnk_n_t  ram_dat_bnk;
    cache_line_off_t ram_dat_idx;
    ram_dat_dat_t    ram_dat_wdata;
    logic            ram_tag_en;
    ways_t           ram_tag_way;
    cache_line_off_t ram_tag_idx;
    cache_line_tag_t ram_tag_wtag;
    logic            ram_tag_wvld;
    logic            crit_vld;
    data_t           crit_data;
    logic            fill_done;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dcache_blocking_fill dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fill_req_vld  (fill_req_vld),
        .fill_req_rdy  (fill_req_rdy),
        .fill_req_addr (fill_req_addr),
        .fill_req_way  (fill_req_way),
        .mem_req_vld   (mem_req_vld),
        .mem_req_rdy   (mem_req_rdy),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_vld   (mem_rsp_vld),
        .mem_rsp_data  (mem_rsp_data),
        .ram_dat_en    (ram_dat_en),
        .ram_dat_way   (ram_dat_way),
        .ram_dat_bnk   (ram_dat_bnk),
        .ram_dat_idx   (ram_dat_idx),
        .ram_dat_wdata (ram_dat_wdata),
        .ram_tag_en    (ram_tag_en),
        .ram_tag_way   (ram_tag_way),
        .ram_tag_idx   (ram_tag_idx),
        .ram_tag_wtag  (ram_tag_wtag),
        .ram_tag_wvld  (ram_tag_wvld),
        .crit_vld      (crit_vld),
        .crit_data     (crit_data),
        .fill_done     (fill_done),
        .busy          (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives four beats starting in the current (first DATA) cycle, then checks TAG.
    task automatic run_beats(input logic [1:0] start, input int gap, input logic hi,
                             input logic [3:0] way, input logic [7:0] idx,
                             input logic [18:0] tag, input logic [63:0] seed);
        logic [63:0] beat;
        logic [1:0]  b;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    mem_rsp_vld = 1'b0;
                    #1;
                    check("gap_dat_en", 64'(ram_dat_en), 64'(1'b0));
                    tick();
                end
            end
            beat         = seed + 64'(i) * 64'h0101_0101_0101_0101;
            b            = start + 2'(i);
            mem_rsp_vld  = 1'b1;
            mem_rsp_data = beat;
            #1;
            check("dat_en",    64'(ram_dat_en),    64'(1'b1));
            check("dat_bnk",   64'(ram_dat_bnk),   64'(4'b0001 << b));
            check("dat_wdata", 64'(ram_dat_wdata), beat);
            check("dat_way",   64'(ram_dat_way),   64'(way));
            check("dat_idx",   64'(ram_dat_idx),   64'(idx));
            check("crit_vld",  64'(crit_vld),      64'(i == 0));
            if (i == 0) check("crit_data", 64'(crit_data), hi ? 64'(beat[63:32]) : 64'(beat[31:0]));
            tick();
        end
        mem_rsp_vld = 1'b0;
        #1;
        check("tag_en",    64'(ram_tag_en),   64'(1'b1));
        check("tag_wvld",  64'(ram_tag_wvld), 64'(1'b1));
        check("tag_wtag",  64'(ram_tag_wtag), 64'(tag));
        check("tag_idx",   64'(ram_tag_idx),  64'(idx));
        check("tag_way",   64'(ram_tag_way),  64'(way));
        check("fill_done", 64'(fill_done),    64'(1'b1));
        tick();
        check("done_pulse", 64'(fill_done), 64'(1'b0));
        check("idle_busy",  64'(busy),      64'(1'b0));
        check("idle_rdy",   64'(fill_req_rdy), 64'(1'b1));
    endtask

    initial begin
        rst_n         = 1'b0;
        fill_req_vld  = 1'b0;
        fill_req_addr = '0;
        fill_req_way  = '0;
        mem_req_rdy   = 1'b0;
        mem_rsp_vld   = 1'b0;
        mem_rsp_data  = '0;
        #1;
        check("rst_rdy",     64'(fill_req_rdy), 64'(1'b0));
        check("rst_busy",    64'(busy),         64'(1'b0));
        check("rst_req_vld", 64'(mem_req_vld),  64'(1'b0));
        check("rst_tag_en",  64'(ram_tag_en),   64'(1'b0));
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_rdy",  64'(fill_req_rdy), 64'(1'b1));
        check("post_rst_busy", 64'(busy),         64'(1'b0));

        // Spurious beat while idle.
        mem_rsp_vld  = 1'b1;
        mem_rsp_data = 64'hDEAD_DEAD_DEAD_DEAD;
        #1;
        check("idle_spur_dat_en", 64'(ram_dat_en), 64'(1'b0));
        check("idle_spur_crit",   64'(crit_vld),   64'(1'b0));
        tick();
        mem_rsp_vld = 1'b0;

        // Fill 1: 0x1234, way 0010, back-to-back beats, banks 2,3,0,1, upper critical word.
        fill_req_vld  = 1'b1;
        fill_req_addr = 32'h0000_1234;
        fill_req_way  = 4'b0010;
        mem_req_rdy   = 1'b1;
        #1;
        check("f1_rdy", 64'(fill_req_rdy), 64'(1'b1));
        tick();
        fill_req_vld = 1'b0;
        #1;
        check("f1_inv_en",   64'(ram_tag_en),   64'(1'b1));
        check("f1_inv_wvld", 64'(ram_tag_wvld), 64'(1'b0));
        check("f1_inv_idx",  64'(ram_tag_idx),  64'h91);
        check("f1_inv_way",  64'(ram_tag_way),  64'(4'b0010));
        check("f1_inv_busy", 64'(busy),         64'(1'b1));
        check("f1_inv_rdy",  64'(fill_req_rdy), 64'(1'b0));
        check("f1_inv_done", 64'(fill_done),    64'(1'b0));
        tick();
        mem_rsp_vld = 1'b1;
        #1;
        check("f1_req_vld",      64'(mem_req_vld),  64'(1'b1));
        check("f1_req_addr",     64'(mem_req_addr), 64'h1230);
        check("req_spur_dat_en", 64'(ram_dat_en),   64'(1'b0));
        tick();
        run_beats(2'd2, 0, 1'b1, 4'b0010, 8'h91, 19'h00000, 64'h1111_2222_3333_4444);

        // Fill 2: address 0, request stalled for 5 cycles, banks 0,1,2,3.
        fill_req_vld  = 1'b1;
        fill_req_addr = 32'h0000_0000;
        fill_req_way  = 4'b0001;
        mem_req_rdy   = 1'b0;
        tick();
        fill_req_vld = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            check("f2_stall_vld",  64'(mem_req_vld),  64'(1'b1));
            check("f2_stall_addr", 64'(mem_req_addr), 64'h0);
            check("f2_stall_dat",  64'(ram_dat_en),   64'(1'b0));
            tick();
        end
        mem_req_rdy = 1'b1;
        #1;
        check("f2_accept_vld", 64'(mem_req_vld), 64'(1'b1));
        tick();
        mem_req_rdy = 1'b0;
        run_beats(2'd0, 0, 1'b0, 4'b0001, 8'h00, 19'h00000, 64'hAAAA_5555_CCCC_3333);

        // Fill 3: 0xDEADBEEC with one idle cycle between beats, banks 1,2,3,0.
        fill_req_vld  = 1'b1;
        fill_req_addr = 32'hDEAD_BEEC;
        fill_req_way  = 4'b1000;
        mem_req_rdy   = 1'b1;
        tick();
        fill_req_vld = 1'b0;
        tick();
        #1;
        check("f3_req_addr", 64'(mem_req_addr), 64'hDEAD_BEE8);
        tick();
        run_beats(2'd1, 1, 1'b1, 4'b1000, 8'hF7, 19'h6F56D, 64'h0123_4567_89AB_CDEF);

        // Fill 4: reset asserted after the second beat.
        fill_req_vld  = 1'b1;
        fill_req_addr = 32'h0000_0040;
        fill_req_way  = 4'b0100;
        tick();
        fill_req_vld = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            mem_rsp_vld  = 1'b1;
            mem_rsp_data = 64'h5A5A_0000_0000_0000 + 64'(i);
            #1;
            check("f4_beat_en", 64'(ram_dat_en), 64'(1'b1));
            tick();
        end
        mem_rsp_vld = 1'b0;
        rst_n       = 1'b0;
        #1;
        check("f4_rst_tag_en", 64'(ram_tag_en), 64'(1'b0));
        check("f4_rst_busy",   64'(busy),       64'(1'b0));
        tick();
        rst_n = 1'b1;
        #1;
        check("f4_after_busy",   64'(busy),         64'(1'b0));
        check("f4_after_rdy",    64'(fill_req_rdy), 64'(1'b1));
        check("f4_after_tag_en", 64'(ram_tag_en),   64'(1'b0));
        check("f4_after_done",   64'(fill_done),    64'(1'b0));
        mem_rsp_vld = 1'b1;
        #1;
        check("f4_stale_beat_en", 64'(ram_dat_en), 64'(1'b0));
        tick();
        mem_rsp_vld = 1'b0;

        // Fills 5/6: second request held valid during the first.
        fill_req_vld  = 1'b1;
        fill_req_addr = 32'h0000_0100;
        fill_req_way  = 4'b0100;
        mem_req_rdy   = 1'b1;
        tick();
        fill_req_addr = 32'h0000_0218;
        fill_req_way  = 4'b0010;
        #1;
        check("f5_inv_idx",  64'(ram_tag_idx),  64'h08);
        check("f5_busy_rdy", 64'(fill_req_rdy), 64'(1'b0));
        tick();
        #1;
        check("f5_req_addr", 64'(mem_req_addr), 64'h100);
        tick();
        run_beats(2'd0, 0, 1'b0, 4'b0100, 8'h08, 19'h00000, 64'hFEDC_BA98_7654_3210);
        tick();
        fill_req_vld = 1'b0;
        #1;
        check("f6_inv_en",   64'(ram_tag_en),   64'(1'b1));
        check("f6_inv_wvld", 64'(ram_tag_wvld), 64'(1'b0));
        check("f6_inv_idx",  64'(ram_tag_idx),  64'h10);
        check("f6_inv_way",  64'(ram_tag_way),  64'(4'b0010));
        tick();
        #1;
        check("f6_req_addr", 64'(mem_req_addr), 64'h218);
        tick();
        run_beats(2'd3, 0, 1'b0, 4'b0010, 8'h10, 19'h00000, 64'h0F0F_1E1E_2D2D_3C3C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcache_blocking_fill.md
# dcache_blocking_fill

Line-fill engine directly downstream of the dcache_blocking miss path. It accepts one miss (address plus victim way) and invalidates the victim tag. It then fetches the 32-byte line from memory as four 64-bit beats, critical beat first, writes each beat into the data RAM bank, forwards the critical 32-bit word to the load pipeline, and finally writes the new valid tag.

## Interface
Parameters: none. All sizes come from dcache_blocking_pkg (DATA_W=32, MEM_DATA_W=64, RAM_DAT_LINE_N=4, RAM_TAG_ADDR_W=8, CACHE_LINE_TAG_W=19, CACHE_WAYS_N=4).

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
- fill_req_vld  in  1  miss request valid
- fill_req_rdy  out  1  engine idle, request accepted when vld&rdy
- fill_req_addr  in  addr_t  faulting byte address
- fill_req_way  in  ways_t  victim way, one-hot
- mem_req_vld  out  1  memory read request valid
- mem_req_rdy  in  1  memory accepts request
- mem_req_addr  out  addr_t  line address: p.o=0, p.b=critical bank
- mem_rsp_vld  in  1  beat valid; no back-pressure
- mem_rsp_data  in  mem_data_t  beat data
- ram_dat_en  out  1  data RAM write strobe
- ram_dat_way  out  ways_t  way select
- ram_dat_bnk  out  ram_dat_bnk_n_t  bank select, one-hot
- ram_dat_idx  out  cache_line_off_t  set index
- ram_dat_wdata  out  ram_dat_dat_t  write data
- ram_tag_en  out  1  tag RAM write strobe
- ram_tag_way  out  ways_t  way select
- ram_tag_idx  out  cache_line_off_t  set index
- ram_tag_wtag  out  cache_line_tag_t  tag value
- ram_tag_wvld  out  1  valid bit written
- crit_vld  out  1  critical word valid, one-cycle pulse
- crit_data  out  data_t  critical word
- fill_done  out  1  one-cycle pulse, line installed
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, INV, REQ, DATA, TAG.
- IDLE: fill_req_rdy=1. On handshake, capture addr and way, set start bank = addr.p.b, go to INV.
- INV: one cycle. ram_tag_en=1, ram_tag_wvld=0 for the captured way and index (l.o). This removes the victim before any data is overwritten. Then go to REQ.
- REQ: mem_req_vld=1 is held, with stable mem_req_addr, until mem_req_rdy. Then clear the 2-bit beat counter and go to DATA.
- DATA: on each mem_rsp_vld:
  - ram_dat_en=1 in the same cycle (combinational from mem_rsp_vld).
  - bank = (start + cnt) mod 4, with 2-bit wrap-around. Data = mem_rsp_data.
  - cnt increments.
- On beat cnt==0, crit_vld=1 in the same cycle. crit_data = mem_rsp_data[63:32] if addr.p.o[2] else [31:0].
- The beat with cnt==3 moves the FSM to TAG.
- TAG: one cycle. ram_tag_en=1, ram_tag_wvld=1, ram_tag_wtag=l.t. fill_done=1. Return to IDLE.
- mem_rsp_vld outside DATA is ignored, with no RAM write. Flagged by assertion.
- Reset values: state IDLE, cnt 0. All strobes/pulses (mem_req_vld, ram_*_en, crit_vld, fill_done, busy) are 0; fill_req_rdy is 0 while rst_n=0. Data/address outputs read 0.
- Reset mid-fill: return to IDLE next edge with no tag write. A victim invalidated in INV stays invalid, so partial data is never visible.

## Timing
- fill_req handshake at cycle T. INV at T+1. REQ from T+2; with mem_req_rdy high, the request is accepted at T+2.
- Beats arrive at any cycle after acceptance and may have gaps. With back-to-back beats starting at T+3, TAG/fill_done occurs at T+7.
- Minimum occupancy is 7 cycles. fill_req_rdy returns at T+8, so a new request can be accepted at T+8.
- ram_dat/crit outputs are combinational from mem_rsp_*, in the same cycle. ram_tag outputs are decoded from registered state.

## Structure
- Add to dcache_blocking_pkg: fill_state_t enum (IDLE, INV, REQ, DATA, TAG) and function bank_onehot(ram_dat_line_t) returning ram_dat_bnk_n_t.
- No sub-modules: one FSM plus a counter fits in a single module.

## Test plan
- addr=0x0000_1234, way=4'b0010, 4 back-to-back beats. Expected:
  - INV write at idx 0x91, wvld=0.
  - mem_req_addr=0x0000_1230. Banks written in order 2,3,0,1.
  - crit_data = beat0[63:32].
  - Tag 0x00000, wvld=1, fill_done at T+7.
- addr=0x0000_0000 with mem_req_rdy low for 5 cycles. Expected: mem_req_vld and mem_req_addr held stable; banks written 0,1,2,3.
- Gapped beats (1 idle cycle between each). Expected: exactly 4 ram_dat_en pulses; fill_done one cycle after the 4th beat.
- Spurious mem_rsp_vld in IDLE and in REQ. Expected: no RAM writes; assertion fires.
- rst_n low after the 2nd beat. Expected: next cycle IDLE, busy=0, no tag write; a new fill after reset completes normally.
- Two fills back-to-back, the second request held valid during the first. Expected: second accepted exactly when fill_req_rdy returns, no overlap.
